updown_mod_counter: RTL

UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

---
 rtl/updown_mod_counter.sv | 81 ++++++++
 1 files changed

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with programmable step, wrap-or-clamp limits,
// a one-cycle terminal-count pulse and a sticky overflow flag.
module updown_mod_counter #(
  parameter int     WIDTH    = 8,
  parameter longint MODULUS  = 256,
  parameter longint STEP     = 1,
  parameter bit     SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ena,
  input  logic             up,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  // One extra bit of headroom so count+STEP cannot wrap before the compare.
  localparam logic [WIDTH:0]   MOD_X   = MODULUS[WIDTH:0];
  localparam logic [WIDTH:0]   STEP_X  = STEP[WIDTH:0];
  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

  logic [WIDTH:0]   cnt_ext;
  logic [WIDTH:0]   sum_up;
  logic             up_hit;
  logic             dn_hit;
  logic [WIDTH-1:0] up_next;
  logic [WIDTH-1:0] dn_next;
  logic [WIDTH-1:0] load_next;

  always_comb begin
    cnt_ext   = {1'b0, count};
    sum_up    = cnt_ext + STEP_X;
    up_hit    = (sum_up >= MOD_X);
    dn_hit    = (cnt_ext < STEP_X);
    up_next   = sum_up[WIDTH-1:0];
    dn_next   = WIDTH'(cnt_ext - STEP_X);
    load_next = load_val;

    if (up_hit)
      up_next = SATURATE ? MAX_CNT : WIDTH'(sum_up - MOD_X);
    if (dn_hit)
      dn_next = SATURATE ? '0 : WIDTH'(cnt_ext + MOD_X - STEP_X);
    if ({1'b0, load_val} >= MOD_X)
      load_next = MAX_CNT;
  end

  // Unknown ena/up falls through to the last branch so X propagates in
  // simulation; synthesis treats it as don't-care.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else if (clear) begin
      count <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else if (load) begin
      count <= load_next;
      tc    <= 1'b0;
    end else if (ena == 1'b0) begin
      tc    <= 1'b0;
    end else if (ena == 1'b1 && up == 1'b1) begin
      count <= up_next;
      tc    <= up_hit;
      ovf   <= ovf | up_hit;
    end else if (ena == 1'b1 && up == 1'b0) begin
      count <= dn_next;
      tc    <= dn_hit;
      ovf   <= ovf | dn_hit;
    end else begin
      count <= 'x;
      tc    <= 1'bx;
    end
  end

endmodule
